line_buff_ctrl: RTL

//  Sequencer for the ping-pong line buffer pair (A=idx0, B=idx1); sits between the VGA timing generator and line_buffers.

---
 rtl/vga_pkg.sv | 20 ++
 rtl/line_buff_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/vga_pkg.sv
// Shared types and default geometry for the VGA line-buffer path.
package vga_pkg;

    typedef enum logic [1:0] {
        WAIT_VBLANK = 2'd0,
        PREFILL_A   = 2'd1,
        PREFILL_B   = 2'd2,
        DISPLAY     = 2'd3
    } lbc_state_t;

    localparam int BUFF_A = 0;
    localparam int BUFF_B = 1;

    localparam int DEF_WIDTH_PX    = 640;
    localparam int DEF_HEIGHT_PX   = 480;
    localparam int DEF_TILE_WIDTH  = 4;
    localparam int DEF_TILE_HEIGHT = 4;
    localparam int DEF_CNTR_WIDTH  = 10;

endpackage

// File: rtl/line_buff_ctrl.sv
// Ping-pong line buffer sequencer: picks the displayed buffer, drives its tile read
// index and issues one-shot fill requests so each buffer is refilled two tile rows ahead.
module line_buff_ctrl
    import vga_pkg::*;
#(
    parameter int WIDTH_PX         = DEF_WIDTH_PX,
    parameter int HEIGHT_PX        = DEF_HEIGHT_PX,
    parameter int TILE_WIDTH       = DEF_TILE_WIDTH,
    parameter int TILE_HEIGHT      = DEF_TILE_HEIGHT,
    parameter int CNTR_WIDTH       = DEF_CNTR_WIDTH,
    parameter int LBUFF_ADDR_WIDTH = $clog2(WIDTH_PX / TILE_WIDTH)
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic [CNTR_WIDTH-1:0]       pxl_ctr_i,
    input  logic [CNTR_WIDTH-1:0]       ln_ctr_i,
    input  logic [1:0]                  buff_fill_done_i,
    output logic [1:0]                  buff_fill_req_o,
    output logic [1:0]                  buff_sel_o,
    output logic [LBUFF_ADDR_WIDTH-1:0] disp_pxl_id_o,
    output logic                        underrun_o
);

    localparam int HEIGHT_TILES = HEIGHT_PX / TILE_HEIGHT;
    localparam int TROW_W       = $clog2(HEIGHT_TILES);

    localparam logic [CNTR_WIDTH-1:0] WIDTH_C   = CNTR_WIDTH'(WIDTH_PX);
    localparam logic [CNTR_WIDTH-1:0] HEIGHT_C  = CNTR_WIDTH'(HEIGHT_PX);
    localparam logic [CNTR_WIDTH-1:0] TH_MASK   = CNTR_WIDTH'(TILE_HEIGHT - 1);
    localparam logic [CNTR_WIDTH-1:0] TW_C      = CNTR_WIDTH'(TILE_WIDTH);
    localparam logic [TROW_W-1:0]     LAST_ROW  = TROW_W'(HEIGHT_TILES - 1);
    // Last tile row whose release still leaves a row (r+2) to load this frame.
    localparam logic [TROW_W-1:0]     LAST_REFILL_ROW = TROW_W'(HEIGHT_TILES - 3);

    lbc_state_t          state_r, state_next;
    logic [1:0]          req_next, sel_next;
    logic                underrun_next;
    logic [TROW_W-1:0]   tile_row_r;
    logic                fill_pending_r;
    logic                pending_buff_r;

    logic vblank_start, frame_start, row_end, last_row, refill, issue_refill, pending_hit;
    logic [CNTR_WIDTH-1:0] tile_idx;

    assign vblank_start = (ln_ctr_i == HEIGHT_C) && (pxl_ctr_i == '0);
    assign frame_start  = (ln_ctr_i == '0) && (pxl_ctr_i == '0);
    assign row_end      = (pxl_ctr_i == WIDTH_C) && (ln_ctr_i < HEIGHT_C)
                        && ((ln_ctr_i & TH_MASK) == TH_MASK);
    assign last_row     = (tile_row_r == LAST_ROW);
    assign refill       = (tile_row_r <= LAST_REFILL_ROW);
    assign issue_refill = (state_r == DISPLAY) && row_end && !last_row && refill;
    assign pending_hit  = fill_pending_r && buff_fill_done_i[pending_buff_r];

    assign tile_idx      = pxl_ctr_i / TW_C;
    assign disp_pxl_id_o = (pxl_ctr_i < WIDTH_C) ? tile_idx[LBUFF_ADDR_WIDTH-1:0] : '0;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r         <= WAIT_VBLANK;
            buff_fill_req_o <= '0;
            buff_sel_o      <= '0;
            underrun_o      <= 1'b0;
        end else begin
            state_r         <= state_next;
            buff_fill_req_o <= req_next;
            buff_sel_o      <= sel_next;
            underrun_o      <= underrun_next;
        end
    end

    always_comb begin
        state_next = state_r;
        case (state_r)
            WAIT_VBLANK: if (vblank_start)               state_next = PREFILL_A;
            PREFILL_A:   if (buff_fill_done_i[BUFF_A])   state_next = PREFILL_B;
            PREFILL_B:   if (buff_fill_done_i[BUFF_B])   state_next = DISPLAY;
            DISPLAY:     if (row_end && last_row)        state_next = PREFILL_A;
            default:                                     state_next = WAIT_VBLANK;
        endcase
    end

    always_comb begin
        req_next      = 2'b00;
        sel_next      = buff_sel_o;
        underrun_next = underrun_o;
        case (state_r)
            WAIT_VBLANK: begin
                if (vblank_start) req_next = 2'b01;
            end
            PREFILL_A: begin
                if (frame_start)               underrun_next = 1'b1;
                if (buff_fill_done_i[BUFF_A])  req_next      = 2'b10;
            end
            PREFILL_B: begin
                if (frame_start)               underrun_next = 1'b1;
                if (buff_fill_done_i[BUFF_B])  sel_next      = 2'b01;
            end
            DISPLAY: begin
                if (row_end) begin
                    if (fill_pending_r) underrun_next = 1'b1;
                    if (last_row) begin
                        sel_next = 2'b00;
                        req_next = 2'b01;
                    end else begin
                        sel_next = ~buff_sel_o;
                        // The buffer just released goes back for row r+2.
                        if (refill) req_next = buff_sel_o;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tile_row_r     <= '0;
            fill_pending_r <= 1'b0;
            pending_buff_r <= 1'b0;
        end else begin
            if ((state_r == PREFILL_B) && buff_fill_done_i[BUFF_B]) begin
                tile_row_r     <= '0;
                fill_pending_r <= 1'b0;
            end else begin
                if ((state_r == DISPLAY) && row_end && !last_row)
                    tile_row_r <= tile_row_r + 1'b1;
                if (issue_refill) begin
                    fill_pending_r <= 1'b1;
                    pending_buff_r <= buff_sel_o[BUFF_B];
                end else if (pending_hit) begin
                    fill_pending_r <= 1'b0;
                end
            end
        end
    end

endmodule
